// File: rtl/xram_read_responder_if.sv
// 8051 XRAM command bus as seen by a responder: command/address/data in, stall and read data out.
interface xram_read_responder_if;
   logic [1:0]  cmd;
   logic [15:0] cmdaddr;
   logic [7:0]  cmddata;
   logic        stall;
   logic [7:0]  dataout;
   logic        dataout_vld;

   modport master (
      output cmd, cmdaddr, cmddata,
      input  stall, dataout, dataout_vld
   );

   modport slave (
      input  cmd, cmdaddr, cmddata,
      output stall, dataout, dataout_vld
   );
endinterface

// File: rtl/xram_read_responder.sv
// XRAM bus responder: local scratch RAM reads/writes, and read forwarding to the AES/SHA
// register windows over req/ack ports with an ack timeout.
module xram_read_responder #(
   parameter logic [15:0] AES_BASE = 16'hFF00,
   parameter int unsigned AES_SIZE = 48,
   parameter logic [15:0] SHA_BASE = 16'hFE00,
   parameter int unsigned SHA_SIZE = 64,
   parameter int unsigned RAM_AW   = 10,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   xram_read_responder_if.slave       bus,
   output logic                       aes_rd_req,
   output logic [7:0]                 aes_rd_addr,
   input  logic                       aes_rd_ack,
   input  logic [7:0]                 aes_rd_data,
   output logic                       sha_rd_req,
   output logic [7:0]                 sha_rd_addr,
   input  logic                       sha_rd_ack,
   input  logic [7:0]                 sha_rd_data
);

   localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);
   localparam logic [16:0] AesEnd = {1'b0, AES_BASE} + 17'(AES_SIZE);
   localparam logic [16:0] ShaEnd = {1'b0, SHA_BASE} + 17'(SHA_SIZE);

   typedef enum logic [2:0] {
      StIdle,
      StLread,
      StWaitAes,
      StWaitSha,
      StResp
   } state_e;

   state_e            state_q;
   logic [RAM_AW-1:0] raddr_q;
   logic [7:0]        data_q;
   logic [CntW-1:0]   cnt_q;
   logic              aes_req_q;
   logic              sha_req_q;
   logic [7:0]        aes_addr_q;
   logic [7:0]        sha_addr_q;
   logic              vld_q;

   logic [7:0] ram [2**RAM_AW];

   logic [16:0] addr_ext;
   logic        in_aes;
   logic        in_sha;
   logic        ram_we;
   logic        acc_ack;
   logic [7:0]  acc_data;

   always_comb begin
      addr_ext = {1'b0, bus.cmdaddr};
      in_aes   = (addr_ext >= {1'b0, AES_BASE}) && (addr_ext < AesEnd);
      in_sha   = (addr_ext >= {1'b0, SHA_BASE}) && (addr_ext < ShaEnd);
      // Window writes are left to the accelerators, which snoop the same bus.
      ram_we   = !rst && (state_q == StIdle) && (bus.cmd == 2'd2) && !in_aes && !in_sha;
      acc_ack  = (state_q == StWaitAes) ? aes_rd_ack  : sha_rd_ack;
      acc_data = (state_q == StWaitAes) ? aes_rd_data : sha_rd_data;
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[bus.cmdaddr[RAM_AW-1:0]] <= bus.cmddata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         raddr_q    <= '0;
         data_q     <= '0;
         cnt_q      <= '0;
         aes_req_q  <= 1'b0;
         sha_req_q  <= 1'b0;
         aes_addr_q <= '0;
         sha_addr_q <= '0;
         vld_q      <= 1'b0;
      end else begin
         vld_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.cmd == 2'd1) begin
                  raddr_q <= bus.cmdaddr[RAM_AW-1:0];
                  cnt_q   <= '0;
                  if (in_aes) begin
                     state_q    <= StWaitAes;
                     aes_req_q  <= 1'b1;
                     aes_addr_q <= 8'(bus.cmdaddr - AES_BASE);
                  end else if (in_sha) begin
                     state_q    <= StWaitSha;
                     sha_req_q  <= 1'b1;
                     sha_addr_q <= 8'(bus.cmdaddr - SHA_BASE);
                  end else begin
                     state_q <= StLread;
                  end
               end
            end
            StLread: begin
               data_q  <= ram[raddr_q];
               vld_q   <= 1'b1;
               state_q <= StResp;
            end
            StWaitAes, StWaitSha: begin
               // A silent accelerator reads back as 8'hFF after TIMEOUT cycles.
               if (acc_ack || (cnt_q == CntMax)) begin
                  data_q    <= acc_ack ? acc_data : 8'hFF;
                  aes_req_q <= 1'b0;
                  sha_req_q <= 1'b0;
                  vld_q     <= 1'b1;
                  state_q   <= StResp;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   always_comb begin
      unique case (state_q)
         StIdle:                        bus.stall = (bus.cmd == 2'd1);
         StLread, StWaitAes, StWaitSha: bus.stall = 1'b1;
         default:                       bus.stall = 1'b0;
      endcase
   end

   assign bus.dataout     = data_q;
   assign bus.dataout_vld = vld_q;
   assign aes_rd_req      = aes_req_q;
   assign aes_rd_addr     = aes_addr_q;
   assign sha_rd_req      = sha_req_q;
   assign sha_rd_addr     = sha_addr_q;

endmodule
